// File: rtl/vec_lsu_sequencer_if.sv
// Bus interface for the vector load/store sequencer.
// Groups every signal except clk/rst_n into a single bundle:
//   request channel  : req_valid/req_ready, req_we, req_bank, req_base, req_stride, req_count
//   store data       : wd_valid/wd_ready, wd_data
//   load data        : rd_valid/rd_ready, rd_data
//   memory side      : mem_addr, mem_we, mem_wd, mem_sel, mem_rd
//   status           : busy, done
// The slave modport is the sequencer's view. The master modport is the view of
// whatever drives requests and plays the memory, e.g. a testbench.
interface vec_lsu_sequencer_if #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
);
  localparam int DATA_W = LANES * LANE_W;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [3:0]        req_bank;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_stride;
  logic [CNT_W-1:0]  req_count;

  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd;
  logic [3:0]        mem_sel;
  logic [DATA_W-1:0] mem_rd;

  logic              busy;
  logic              done;

  modport slave (
    input  req_valid, req_we, req_bank, req_base, req_stride, req_count,
    input  wd_valid, wd_data, rd_ready, mem_rd,
    output req_ready, wd_ready, rd_valid, rd_data,
    output mem_addr, mem_we, mem_wd, mem_sel, busy, done
  );

  modport master (
    output req_valid, req_we, req_bank, req_base, req_stride, req_count,
    output wd_valid, wd_data, rd_ready, mem_rd,
    input  req_ready, wd_ready, rd_valid, rd_data,
    input  mem_addr, mem_we, mem_wd, mem_sel, busy, done
  );
endinterface

// File: rtl/vec_lsu_sequencer.sv
// Vector load/store sequencer sitting directly in front of the vector data memory.
// One strided request (base, stride, beat count, bank, load/store) is accepted in
// IDLE and turned into one full-width vector access per beat at base + i*stride.
// Loads are captured one cycle after the address into a 2-entry output FIFO;
// stores pass wd_data straight through to the memory on each wd handshake.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - vec_lsu_sequencer_if.slave: request, store data, load data,
//            memory address/write/bank-select/read data, busy and done status
module vec_lsu_sequencer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vec_lsu_sequencer_if.slave   bus
);
  localparam int DATA_W = LANES * LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_DRAIN,
    ST_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]  beats_left_q, beats_left_d;
  logic [3:0]        sel_q, sel_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic [1:0]        fifo_count_q, fifo_count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic rd_valid;
  logic issue;
  logic push;
  logic pop;
  logic store_beat;

  // A read may only be issued when the FIFO is guaranteed to have room for it
  // once it returns, counting the read that is still in flight. The pop of this
  // cycle is deliberately ignored, which keeps the check off the rd_ready path.
  assign rd_valid   = (fifo_count_q != 2'd0);
  assign issue      = (state_q == ST_LOAD) && ((fifo_count_q + {1'b0, inflight_q}) < 2'd2);
  assign push       = inflight_q;
  assign pop        = rd_valid && bus.rd_ready;
  assign store_beat = (state_q == ST_STORE) && bus.wd_valid;

  // Next-state logic: request capture, per-beat address stepping, FSM transitions
  // and the load FIFO bookkeeping. Status outputs are derived from the next state
  // so they come straight out of flops.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    stride_d     = stride_q;
    beats_left_d = beats_left_q;
    sel_d        = sel_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    inflight_d   = issue;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d       = bus.req_base;
          stride_d     = bus.req_stride;
          beats_left_d = bus.req_count;
          sel_d        = bus.req_bank;
          if (bus.req_count == '0) begin
            state_d = ST_FIN;
          end else if (bus.req_we) begin
            state_d = ST_STORE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (issue) begin
          addr_d       = addr_q + stride_q;
          beats_left_d = beats_left_q - CNT_W'(1);
          if (beats_left_q == CNT_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_STORE: begin
        if (store_beat) begin
          addr_d       = addr_q + stride_q;
          beats_left_d = beats_left_q - CNT_W'(1);
          if (beats_left_q == CNT_W'(1)) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (fifo_count_q == 2'd0)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Push and pop in the same cycle are both honoured, leaving the count unchanged.
    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_rd;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    fifo_count_d = fifo_count_q + {1'b0, push} - {1'b0, pop};

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_STORE) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_FIN);
  end

  // All state lives here. Reset drops any in-flight read and empties the FIFO,
  // so an aborted request leaves nothing behind and never produces done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      stride_q     <= '0;
      beats_left_q <= '0;
      sel_q        <= '0;
      inflight_q   <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      fifo_count_q <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      stride_q     <= stride_d;
      beats_left_q <= beats_left_d;
      sel_q        <= sel_d;
      inflight_q   <= inflight_d;
      fifo_q       <= fifo_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Store data is a combinational pass-through so the write lands in the handshake
  // cycle. Because the state is forced to IDLE by reset, a write in a reset cycle
  // is suppressed. rd_data is zeroed whenever the FIFO is empty.
  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_we    = store_beat;
  assign bus.mem_wd    = bus.wd_data;
  assign bus.wd_ready  = (state_q == ST_STORE);
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = rd_valid ? fifo_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_vec_lsu_sequencer.sv
// Self-checking bench for vec_lsu_sequencer.
// The bench plays the vector memory (fixed address-derived contents, one cycle
// read latency) and checks every load beat, store write, status flag and reset
// behaviour against addresses and data computed directly as base + i*stride.
module tb_vec_lsu_sequencer;
  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;
  localparam int DATA_W = LANES * LANE_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;

  vec_lsu_sequencer_if #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  vec_lsu_sequencer #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address, different in every lane.
  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    for (int l = 0; l < LANES; l++) begin
      w[l*LANE_W +: LANE_W] = LANE_W'(int'(a) + l * 40503);
    end
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] randVec();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W / 32; k++) begin
      v[k*32 +: 32] = $urandom;
    end
    return v;
  endfunction

  // Memory model: read data shows up one cycle after the address.
  always @(posedge clk) begin
    bus.mem_rd <= memWord(bus.mem_addr);
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_req_ready", bus.req_ready, 1);
    checkOutput("rst_busy",      bus.busy, 0);
    checkOutput("rst_done",      bus.done, 0);
    checkOutput("rst_mem_we",    bus.mem_we, 0);
    checkOutput("rst_wd_ready",  bus.wd_ready, 0);
    checkOutput("rst_rd_valid",  bus.rd_valid, 0);
    checkOutput("rst_rd_data",   bus.rd_data, 0);
    checkOutput("rst_mem_addr",  bus.mem_addr, 0);
    checkOutput("rst_mem_sel",   bus.mem_sel, 0);
  endtask

  // Runs one request from accept to done.
  // rdMode: 1 = rd_ready always high, 0 = random. holdLow: rd_ready forced low for
  // that many cycles after accept. wdMode: 0 = random, 1 = toggling 1,0,1..., 2 = always.
  task automatic applyStimulus(input logic we, input logic [3:0] bank,
                               input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                               input logic [CNT_W-1:0] count, input int rdMode,
                               input int holdLow, input int wdMode);
    logic [ADDR_W-1:0] expAddr[$];
    logic [DATA_W-1:0] storeVec[$];
    logic [DATA_W-1:0] prevData;
    int wdIdx, wrIdx, rdIdx, since;
    bit accepted, finished, prevHold;
    wdIdx = 0; wrIdx = 0; rdIdx = 0; since = 0;
    accepted = 0; finished = 0; prevHold = 0; prevData = '0;
    for (int i = 0; i < int'(count); i++) begin
      expAddr.push_back(ADDR_W'(int'(base) + i * int'(stride)));
      storeVec.push_back(randVec());
    end

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      if (accepted) since++;
      bus.req_valid  = !accepted;
      bus.req_we     = we;
      bus.req_bank   = bank;
      bus.req_base   = base;
      bus.req_stride = stride;
      bus.req_count  = count;
      case (wdMode)
        0:       bus.wd_valid = 1'($urandom_range(0, 1));
        1:       bus.wd_valid = (since % 2) == 1;
        default: bus.wd_valid = 1'b1;
      endcase
      bus.wd_data = (wdIdx < int'(count)) ? storeVec[wdIdx] : randVec();
      if (holdLow > 0 && since <= holdLow) bus.rd_ready = 1'b0;
      else if (rdMode == 1)                bus.rd_ready = 1'b1;
      else                                 bus.rd_ready = 1'($urandom_range(0, 1));
      #1;

      if (prevHold) begin
        checkOutput("rd_hold_valid", bus.rd_valid, 1);
        checkOutput("rd_hold_data", bus.rd_data, prevData);
      end

      if (!accepted) begin
        checkOutput("idle_req_ready", bus.req_ready, 1);
        accepted = bus.req_ready;
      end else if (bus.done) begin
        finished = 1;
        checkOutput("done_busy", bus.busy, 0);
        checkOutput("done_rd_empty", bus.rd_valid, 0);
        checkOutput("done_beats", we ? wrIdx : rdIdx, count);
        if (count == 0) checkOutput("zero_cnt_latency", since, 1);
      end else begin
        checkOutput("busy", bus.busy, count != 0);
        checkOutput("req_ready_busy", bus.req_ready, 0);
        checkOutput("mem_sel", bus.mem_sel, bank);
        if (since == 1 && count != 0) checkOutput("first_addr", bus.mem_addr, base);
        if (!we && holdLow > 0 && since == holdLow && count >= 2)
          checkOutput("stall_two_issued", bus.mem_addr, ADDR_W'(int'(base) + 2 * int'(stride)));
      end

      if (!we || count == 0) checkOutput("no_store_side", {bus.wd_ready, bus.mem_we}, 0);
      if (bus.mem_we) begin
        checkOutput("we_needs_valid", bus.wd_valid, 1);
        if (wrIdx < int'(count)) begin
          checkOutput("wr_addr", bus.mem_addr, expAddr[wrIdx]);
          checkOutput("wr_data", bus.mem_wd, storeVec[wrIdx]);
          checkOutput("wr_sel", bus.mem_sel, bank);
        end else begin
          checkOutput("extra_write", 1, 0);
        end
        wrIdx++;
      end
      if (bus.wd_valid && bus.wd_ready) wdIdx++;
      if (we && count != 0) checkOutput("we_on_handshake", wrIdx, wdIdx);

      if (bus.rd_valid && bus.rd_ready) begin
        if (rdIdx < int'(count)) checkOutput("rd_data", bus.rd_data, memWord(expAddr[rdIdx]));
        else                     checkOutput("extra_read", 1, 0);
        rdIdx++;
      end
      prevHold = bus.rd_valid && !bus.rd_ready;
      prevData = bus.rd_data;
    end

    if (!finished) checkOutput("done_timeout", 0, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.wd_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    #1;
    checkOutput("done_one_cycle", bus.done, 0);
    checkOutput("back_to_idle", bus.req_ready, 1);
    checkOutput("idle_not_busy", bus.busy, 0);
  endtask

  // Starts an 8-beat request, lets two beats go out, then pulls reset mid-flight.
  task automatic resetMidRequest(input logic we);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    base   = 16'h0200;
    stride = 16'h0004;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_bank   = 4'hA;
    bus.req_base   = base;
    bus.req_stride = stride;
    bus.req_count  = 8'd8;
    bus.rd_ready   = 1'b0;
    bus.wd_valid   = we;
    bus.wd_data    = randVec();
    #1;
    checkOutput("mid_accept", bus.req_ready, 1);
    repeat (3) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    #1;
    checkOutput("mid_pre_busy", bus.busy, 1);
    checkOutput("mid_pre_addr", bus.mem_addr, ADDR_W'(int'(base) + 2 * int'(stride)));
    if (we) checkOutput("mid_pre_we", bus.mem_we, 1);
    else    checkOutput("mid_pre_rd_valid", bus.rd_valid, 1);
    rst_n = 1'b0;
    #1;
    checkResetState();
    @(negedge clk);
    #1;
    checkResetState();
    rst_n        = 1'b1;
    bus.wd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("mid_no_done", bus.done, 0);
      checkOutput("mid_idle_ready", bus.req_ready, 1);
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_bank   = 4'd0;
    bus.req_base   = '0;
    bus.req_stride = '0;
    bus.req_count  = '0;
    bus.wd_valid   = 1'b0;
    bus.wd_data    = '0;
    bus.rd_ready   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkResetState();
    rst_n = 1'b1;

    $display("[TB] directed load, store, wrap, zero-count and stride-0 requests");
    applyStimulus(1'b0, 4'd3, 16'h0010, 16'd6, 8'd4, 1, 0, 0);
    applyStimulus(1'b0, 4'd3, 16'h0010, 16'd6, 8'd4, 0, 5, 0);
    applyStimulus(1'b1, 4'd5, 16'h0100, 16'd1, 8'd3, 1, 0, 1);
    applyStimulus(1'b0, 4'd9, 16'hFFFE, 16'd1, 8'd3, 1, 0, 0);
    applyStimulus(1'b1, 4'd7, 16'h1234, 16'd5, 8'd0, 1, 0, 2);
    applyStimulus(1'b0, 4'd1, 16'h0040, 16'd0, 8'd5, 0, 0, 0);

    $display("[TB] reset in the middle of a load and a store");
    resetMidRequest(1'b0);
    applyStimulus(1'b0, 4'd6, 16'h0300, 16'd2, 8'd4, 1, 0, 0);
    resetMidRequest(1'b1);
    applyStimulus(1'b1, 4'd2, 16'h0400, 16'd3, 8'd4, 0, 0, 0);

    $display("[TB] randomized requests");
    for (int n = 0; n < 24; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom),
                    16'($urandom),
                    ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
                    8'($urandom_range(0, 7)),
                    int'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 4 : 0,
                    ($urandom_range(0, 1) == 0) ? 0 : 2);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
